chamber_pressure_ctrl: RTL and testbench

Bidirectional interlock-chamber pressure sequencer: runs timed pressurize or depressurize cycles on request and tracks whether the chamber is at pressure. It supports abort and rejects illegal or overlapping requests with a pulse. Sits between the interlock door/operator FSM and the pump/vent actuators. Each duration is a parameter (pressurize default 2880 cycles = 8 min at the system tick).

---
 rtl/chamber_pressure_ctrl.sv | 118 +++++++++++
 tb/tb_chamber_pressure_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chamber_pressure_ctrl.sv
// Interlock-chamber pressure sequencer: timed pressurize/depressurize runs with abort and request rejection.
// Optional macro HOLD_EN adds a `hold` input that freezes the run counter while a run is active.
module chamber_pressure_ctrl #(
    parameter int CNT_W            = 12,
    parameter int PRESS_CYCLES     = 2880,
    parameter int DEPRESS_CYCLES   = 2160,
    parameter bit INIT_PRESSURIZED = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic start_press,
    input  logic start_depress,
    input  logic abort,
`ifdef HOLD_EN
    input  logic hold,
`endif
    output logic pressurizing,
    output logic depressurizing,
    output logic pressurized,
    output logic done,
    output logic rejected,
    output logic aborted
);

    typedef enum logic [1:0] {IDLE, PRESS, DEPRESS} state_e;

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPRESS_LAST = CNT_W'(DEPRESS_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, depress_q;
    logic             pressurized_q, pressurized_d;
    logic             done_q, done_d;
    logic             rejected_q, rejected_d;
    logic             aborted_q, aborted_d;
    logic             hold_w;
    logic             last_w;

`ifdef HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign last_w = (state_q == PRESS   && cnt_q == PRESS_LAST) ||
                    (state_q == DEPRESS && cnt_q == DEPRESS_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        pressurized_d = pressurized_q;
        done_d        = 1'b0;
        rejected_d    = 1'b0;
        aborted_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A request is refused if ambiguous or if the chamber is already in the requested state.
                if (press_q && depress_q) begin
                    rejected_d = 1'b1;
                end else if (press_q) begin
                    if (pressurized_q) rejected_d = 1'b1;
                    else               state_d    = PRESS;
                end else if (depress_q) begin
                    if (!pressurized_q) rejected_d = 1'b1;
                    else                state_d    = DEPRESS;
                end
            end
            default: begin
                rejected_d = press_q | depress_q;
                if (abort) begin
                    // Partial run leaves the chamber in an unknown state; treat as not at pressure.
                    state_d       = IDLE;
                    aborted_d     = 1'b1;
                    pressurized_d = 1'b0;
                end else if (hold_w) begin
                    cnt_d = cnt_q;
                end else if (last_w) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    pressurized_d = (state_q == PRESS);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_q       <= 1'b0;
            depress_q     <= 1'b0;
            pressurized_q <= INIT_PRESSURIZED;
            done_q        <= 1'b0;
            rejected_q    <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_q       <= start_press;
            depress_q     <= start_depress;
            pressurized_q <= pressurized_d;
            done_q        <= done_d;
            rejected_q    <= rejected_d;
            aborted_q     <= aborted_d;
        end
    end

    assign pressurizing   = (state_q == PRESS);
    assign depressurizing = (state_q == DEPRESS);
    assign pressurized    = pressurized_q;
    assign done           = done_q;
    assign rejected       = rejected_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_chamber_pressure_ctrl.sv
// Bench for chamber_pressure_ctrl: directed scenarios plus random traffic against a run-length reference model.
module tb_chamber_pressure_ctrl;

    localparam int PC   = 5;
    localparam int DC   = 3;
    localparam bit INIT = 1'b0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_press = 1'b0, start_depress = 1'b0, abort = 1'b0;
`ifdef HOLD_EN
    logic hold = 1'b0;
`endif
    logic pressurizing, depressurizing, pressurized, done, rejected, aborted;

    chamber_pressure_ctrl #(
        .CNT_W(4), .PRESS_CYCLES(PC), .DEPRESS_CYCLES(DC), .INIT_PRESSURIZED(INIT)
    ) dut (
        .clock(clock), .reset(reset),
        .start_press(start_press), .start_depress(start_depress), .abort(abort),
`ifdef HOLD_EN
        .hold(hold),
`endif
        .pressurizing(pressurizing), .depressurizing(depressurizing),
        .pressurized(pressurized), .done(done), .rejected(rejected), .aborted(aborted)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // Reference: which run is active (0 none, 1 press, 2 depress) and how many busy cycles remain.
    int m_run, m_left;
    bit m_rp, m_rd, m_pz, e_done, e_rej, e_ab;

    int w_hi, w_first, w_done, w_ndone, w_rej, w_ab;

    task automatic model_reset();
        m_run = 0; m_left = 0; m_rp = 0; m_rd = 0; m_pz = INIT;
        e_done = 0; e_rej = 0; e_ab = 0;
    endtask

    task automatic model_step(input bit p, input bit d, input bit a, input bit h);
        e_done = 0; e_rej = 0; e_ab = 0;
        if (m_run == 0) begin
            if (m_rp && m_rd)      e_rej = 1;
            else if (m_rp && m_pz) e_rej = 1;
            else if (m_rp)         begin m_run = 1; m_left = PC; end
            else if (m_rd && !m_pz) e_rej = 1;
            else if (m_rd)         begin m_run = 2; m_left = DC; end
        end else begin
            if (m_rp || m_rd) e_rej = 1;
            if (a) begin
                m_run = 0; e_ab = 1; m_pz = 0;
            end else if (!h) begin
                m_left--;
                if (m_left == 0) begin
                    e_done = 1; m_pz = (m_run == 1); m_run = 0;
                end
            end
        end
        m_rp = p; m_rd = d;
    endtask

    function automatic logic [5:0] exp_vec();
        return {m_run == 1, m_run == 2, m_pz, e_done, e_rej, e_ab};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input bit p, input bit d, input bit a, input bit h);
        start_press = p; start_depress = d; abort = a;
`ifdef HOLD_EN
        hold = h;
`endif
        @(posedge clock);
        model_step(p, d, a, h);
        #1;
        chk("cycle", {pressurizing, depressurizing, pressurized, done, rejected, aborted}, exp_vec());
    endtask

    // Idle-input cycles c0..c1 (labels count edges since the request was driven).
    task automatic watch(input int c0, input int c1);
        w_hi = 0; w_first = -1; w_done = -1; w_ndone = 0; w_rej = 0; w_ab = 0;
        for (int c = c0; c <= c1; c++) begin
            cyc(0, 0, 0, 0);
            if (pressurizing | depressurizing) begin
                w_hi++;
                if (w_first < 0) w_first = c;
            end
            if (done) begin w_done = c; w_ndone++; end
            if (rejected) w_rej++;
            if (aborted) w_ab++;
        end
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        chk("async_reset", {pressurizing, depressurizing, pressurized, done, rejected, aborted},
            {5'b0, INIT} << 3);
        #2 reset = 1'b0;
    endtask

    initial begin
        int hh;
        bit rp, rd, ra, rh;
        model_reset();
        #1;
        chk("reset_state", {pressurizing, depressurizing, pressurized, done, rejected, aborted},
            {5'b0, INIT} << 3);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;

        // Pressurize pulse: busy cycles 2..6, done at 7.
        cyc(1, 0, 0, 0);
        watch(2, 9);
        chk("press_first", w_first, 2);
        chk("press_len", w_hi, PC);
        chk("press_done_cyc", w_done, 7);
        chk("press_ndone", w_ndone, 1);
        chk("press_status", pressurized, 1);

        // Press while already pressurized.
        cyc(1, 0, 0, 0);
        watch(2, 5);
        chk("rej_press_cnt", w_rej, 1);
        chk("rej_press_busy", w_hi, 0);

        // Depressurize pulse.
        cyc(0, 1, 0, 0);
        watch(2, 7);
        chk("dep_first", w_first, 2);
        chk("dep_len", w_hi, DC);
        chk("dep_done_cyc", w_done, 5);
        chk("dep_status", pressurized, 0);

        // Both requests together.
        cyc(1, 1, 0, 0);
        watch(2, 5);
        chk("rej_both_cnt", w_rej, 1);
        chk("rej_both_busy", w_hi, 0);

        // Abort on third busy cycle.
        cyc(1, 0, 0, 0);
        watch(2, 4);
        chk("abort3_pre", w_hi, 3);
        cyc(0, 0, 1, 0);
        chk("abort3_pulse", aborted, 1);
        chk("abort3_busy", pressurizing, 0);
        chk("abort3_status", pressurized, 0);
        watch(6, 9);
        chk("abort3_nodone", w_ndone, 0);

        // Abort on final busy cycle.
        cyc(1, 0, 0, 0);
        watch(2, 6);
        chk("abortlast_pre", w_hi, PC);
        cyc(0, 0, 1, 0);
        chk("abortlast_pulse", aborted, 1);
        chk("abortlast_done", done, 0);
        watch(8, 10);
        chk("abortlast_nodone", w_ndone, 0);

        // Held level request during a run: one reject per held cycle.
        cyc(1, 0, 0, 0);
        hh = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            if (rejected) hh++;
        end
        watch(5, 10);
        chk("held_rej", hh + w_rej, 3);
        chk("held_done", w_ndone, 1);

        // Reset mid-depress (pressurized -> INIT), then mid-press.
        cyc(0, 1, 0, 0);
        watch(2, 3);
        pulse_reset();
        cyc(1, 0, 0, 0);
        watch(2, 4);
        pulse_reset();
        cyc(1, 0, 0, 0);
        watch(2, 9);
        chk("post_reset_len", w_hi, PC);
        chk("post_reset_done", w_done, 7);

`ifdef HOLD_EN
        // Hold for four cycles mid-run extends the run by four.
        cyc(0, 1, 0, 0);
        watch(2, 6);
        cyc(1, 0, 0, 0);
        watch(2, 3);
        hh = w_hi;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            if (pressurizing) hh++;
        end
        watch(8, 14);
        chk("hold_len", hh + w_hi, PC + 4);
        chk("hold_ndone", w_ndone, 1);
`endif

        // Random traffic checked against the reference every cycle.
        for (int i = 0; i < 800; i++) begin
            rp = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 15) == 0);
`ifdef HOLD_EN
            rh = ($urandom_range(0, 3) == 0);
`else
            rh = 1'b0;
`endif
            cyc(rp, rd, ra, rh);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
